// File: rtl/branch_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_control_pkg
// Purpose  : Shared types and constants for the branch_control sequencer:
//            sequencer state encoding, branch opcodes, halt word, default widths.
// Revision : 1.0 - initial release
// ============================================================================
package branch_control_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Branch opcodes live in the top four instruction bits
  localparam logic [3:0] OP_JMP     = 4'b1101;
  localparam logic [3:0] OP_BRF     = 4'b1110;
  localparam logic [8:0] HALT_INSTR = 9'h1FF;

  // Default widths
  localparam int ADDR_W_DEF   = 7;
  localparam int OFFSET_W_DEF = 5;
  localparam int INSTR_W_DEF  = 9;
  localparam int CNT_W        = 16;

endpackage : branch_control_pkg
`default_nettype wire

// File: rtl/branch_control_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter with synchronous clear and enable that sticks at its
//            all-ones value instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter
  import branch_control_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear has priority, increment stops at the ceiling
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/branch_control.sv
`default_nettype none
// ============================================================================
// Module   : branch_control
// Purpose  : Program sequencer and branch decoder in front of the fetch unit.
//            Runs a request/done handshake with the host, parks the PC at the
//            selected program entry while idle and decodes JMP/BRF/HALT while
//            running. Optional performance counters are built when the macro
//            BRANCH_CONTROL_PERF_EN is defined; otherwise the count outputs
//            are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module branch_control
  import branch_control_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                OFFSET_W   = OFFSET_W_DEF,
  parameter int                INSTR_W    = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] PROG0_ADDR = 7'd0,
  parameter logic [ADDR_W-1:0] PROG1_ADDR = 7'd32,
  parameter logic [ADDR_W-1:0] PROG2_ADDR = 7'd64,
  parameter logic [ADDR_W-1:0] PROG3_ADDR = 7'd96
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                request,
  input  logic [1:0]          program_select,
  input  logic [INSTR_W-1:0]  instruction,
  input  logic                flag_we,
  input  logic                flag_in,
  output logic                start,
  output logic [ADDR_W-1:0]   start_address,
  output logic                branch,
  output logic                taken,
  output logic [OFFSET_W-1:0] offset,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    taken_count
);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       flag_q, flag_d;

  logic [3:0] opcode;
  logic       is_halt;

  assign opcode  = instruction[INSTR_W-1 -: 4];
  assign is_halt = (instruction == INSTR_W'(HALT_INSTR));

  // Program entry point lookup
  function automatic logic [ADDR_W-1:0] entry(input logic [1:0] s);
    case (s)
      2'd0:    entry = PROG0_ADDR;
      2'd1:    entry = PROG1_ADDR;
      2'd2:    entry = PROG2_ADDR;
      default: entry = PROG3_ADDR;
    endcase
  endfunction

  // Sequencer next state and handshake outputs; the PC is kept parked on an
  // entry point in every state except RUN
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    start         = 1'b0;
    start_address = entry(sel_q);
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start         = 1'b1;
        start_address = entry(program_select);
        if (request) begin
          state_d = ST_START;
          sel_d   = program_select;
        end
      end
      ST_START: begin
        start   = 1'b1;
        busy    = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (is_halt) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        start = 1'b1;
        done  = 1'b1;
        if (!request) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Branch decode, only active while running; HALT never branches
  always_comb begin
    branch = 1'b0;
    taken  = 1'b0;
    offset = '0;
    if (state_q == ST_RUN) begin
      offset = instruction[OFFSET_W-1:0];
      if (!is_halt) begin
        case (opcode)
          OP_JMP: begin
            branch = 1'b1;
            taken  = 1'b1;
          end
          OP_BRF: begin
            branch = 1'b1;
            taken  = flag_q;
          end
          default: begin
            branch = 1'b0;
            taken  = 1'b0;
          end
        endcase
      end
    end
  end

  // Condition flag: START clear beats a concurrent execute-stage write
  always_comb begin
    flag_d = flag_q;
    if (state_q == ST_START) begin
      flag_d = 1'b0;
    end else if (flag_we) begin
      flag_d = flag_in;
    end
  end

  // State, latched program select and flag registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      flag_q  <= flag_d;
    end
  end

`ifdef BRANCH_CONTROL_PERF_EN
  logic cnt_clear;
  logic cyc_en;
  logic tkn_en;

  assign cnt_clear = (state_q == ST_START);
  assign cyc_en    = (state_q == ST_RUN);
  assign tkn_en    = branch & taken;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (cnt_clear),
    .enable_i (cyc_en),
    .count_o  (cycle_count)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_taken_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (cnt_clear),
    .enable_i (tkn_en),
    .count_o  (taken_count)
  );
`else
  assign cycle_count = '0;
  assign taken_count = '0;
`endif

endmodule : branch_control
`default_nettype wire

// File: tb/tb_branch_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_control
// Purpose  : Self-checking bench for branch_control: handshake sequencing,
//            branch decode table, flag timing, async reset and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_control;

`ifdef BRANCH_CONTROL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [8:0] NOP  = 9'h000;
  localparam logic [8:0] HALT = 9'h1FF;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        request;
  logic [1:0]  program_select;
  logic [8:0]  instruction;
  logic        flag_we;
  logic        flag_in;
  logic        start;
  logic [6:0]  start_address;
  logic        branch;
  logic        taken;
  logic [4:0]  offset;
  logic        busy;
  logic        done;
  logic [15:0] cycle_count;
  logic [15:0] taken_count;

  int n_cmp = 0;
  int n_err = 0;

  branch_control dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .request        (request),
    .program_select (program_select),
    .instruction    (instruction),
    .flag_we        (flag_we),
    .flag_in        (flag_in),
    .start          (start),
    .start_address  (start_address),
    .branch         (branch),
    .taken          (taken),
    .offset         (offset),
    .busy           (busy),
    .done           (done),
    .cycle_count    (cycle_count),
    .taken_count    (taken_count)
  );

  always #5 clock = ~clock;

  // Expected observable outputs for one cycle
  typedef struct packed {
    logic       start;
    logic [6:0] addr;
    logic       chk_addr;
    logic       busy;
    logic       done;
    logic       branch;
    logic       taken;
    logic [4:0] offset;
  } exp_t;

  // Decode vector applied while running
  typedef struct packed {
    logic [8:0] instr;
    logic       fwe;
    logic       fin;
    logic       req;
    logic       eb;
    logic       et;
    logic [4:0] eoff;
  } vec_t;

  exp_t sbq[$];

  function automatic logic [15:0] ec(input int v);
    return PERF ? 16'(v) : 16'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input logic st, input logic [6:0] a, input logic ca,
                            input logic b, input logic d, input logic br,
                            input logic tk, input logic [4:0] off);
    exp_t e;
    e.start = st; e.addr = a; e.chk_addr = ca; e.busy = b; e.done = d;
    e.branch = br; e.taken = tk; e.offset = off;
    sbq.push_back(e);
  endtask

  task automatic sb_check(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, nothing expected", nm);
      return;
    end
    e = sbq.pop_front();
    chk({nm, ".start"},  start,  e.start);
    if (e.chk_addr) chk({nm, ".start_address"}, start_address, e.addr);
    chk({nm, ".busy"},   busy,   e.busy);
    chk({nm, ".done"},   done,   e.done);
    chk({nm, ".branch"}, branch, e.branch);
    chk({nm, ".taken"},  taken,  e.taken);
    chk({nm, ".offset"}, offset, e.offset);
  endtask

  // Inputs change just after the active edge; outputs are sampled mid-cycle
  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  vec_t vecs[9];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{instr: 9'h1C1, fwe: 0, fin: 0, req: 1, eb: 1, et: 0, eoff: 5'h01};
    vecs[1] = '{instr: 9'h1BE, fwe: 0, fin: 0, req: 1, eb: 1, et: 1, eoff: 5'h1E};
    vecs[2] = '{instr: 9'h1C3, fwe: 1, fin: 1, req: 1, eb: 1, et: 0, eoff: 5'h03};
    vecs[3] = '{instr: 9'h1C5, fwe: 1, fin: 0, req: 1, eb: 1, et: 1, eoff: 5'h05};
    vecs[4] = '{instr: 9'h1DF, fwe: 0, fin: 0, req: 1, eb: 1, et: 0, eoff: 5'h1F};
    vecs[5] = '{instr: 9'h187, fwe: 0, fin: 0, req: 0, eb: 0, et: 0, eoff: 5'h07};
    vecs[6] = '{instr: 9'h1FE, fwe: 0, fin: 0, req: 0, eb: 0, et: 0, eoff: 5'h1E};
    vecs[7] = '{instr: 9'h1A0, fwe: 0, fin: 0, req: 0, eb: 1, et: 1, eoff: 5'h00};
    vecs[8] = '{instr: HALT,   fwe: 0, fin: 0, req: 0, eb: 0, et: 0, eoff: 5'h1F};

    // ---------------- reset / idle parking ----------------
    reset_n = 1'b0; request = 1'b0; program_select = 2'd2;
    instruction = NOP; flag_we = 1'b0; flag_in = 1'b0;
    expect_out(1, 7'd64, 1, 0, 0, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("reset");
    chk("reset.cycle_count", cycle_count, 16'd0);
    chk("reset.taken_count", taken_count, 16'd0);
    next_cyc();
    reset_n = 1'b1;
    expect_out(1, 7'd64, 1, 0, 0, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("idle_sel2");

    // ---------------- NOP, NOP, HALT on program 1 ----------------
    next_cyc();
    request = 1'b1; program_select = 2'd1;
    expect_out(1, 7'd32, 1, 0, 0, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("idle_req");
    next_cyc();                         // START
    program_select = 2'd3; instruction = 9'h1BE;
    expect_out(1, 7'd32, 1, 1, 0, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("start_cycle");
    next_cyc(); instruction = NOP;      // RUN 1
    expect_out(0, 7'd0, 0, 1, 0, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("run_nop1");
    chk("run_nop1.cycle_count", cycle_count, 16'd0);
    next_cyc(); instruction = NOP;      // RUN 2
    expect_out(0, 7'd0, 0, 1, 0, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("run_nop2");
    next_cyc(); instruction = HALT;     // RUN 3
    expect_out(0, 7'd0, 0, 1, 0, 0, 0, 5'h1F);
    @(negedge clock);
    sb_check("run_halt");
    next_cyc(); instruction = NOP;      // DONE
    expect_out(1, 7'd32, 1, 0, 1, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("done1");
    chk("done1.cycle_count", cycle_count, ec(3));
    chk("done1.taken_count", taken_count, 16'd0);
    next_cyc();                         // DONE held by request
    expect_out(1, 7'd32, 1, 0, 1, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("done_hold");
    chk("done_hold.cycle_count", cycle_count, ec(3));
    next_cyc(); request = 1'b0;         // still DONE this cycle
    expect_out(1, 7'd32, 1, 0, 1, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("done_req_low");
    next_cyc();                         // back to IDLE
    expect_out(1, 7'd96, 1, 0, 0, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("idle_after_done");
    chk("idle.cycle_count_hold", cycle_count, ec(3));

    // ---------------- decode table on program 3 ----------------
    next_cyc();
    request = 1'b1; program_select = 2'd3;
    flag_we = 1'b1; flag_in = 1'b1;     // set flag in IDLE; START must clear it
    expect_out(1, 7'd96, 1, 0, 0, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("idle_req3");
    next_cyc();                         // START
    flag_we = 1'b0; flag_in = 1'b0;
    expect_out(1, 7'd96, 1, 1, 0, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("start3");
    for (int i = 0; i < 9; i++) begin
      next_cyc();
      instruction = vecs[i].instr;
      flag_we     = vecs[i].fwe;
      flag_in     = vecs[i].fin;
      request     = vecs[i].req;
      expect_out(0, 7'd0, 0, 1, 0, vecs[i].eb, vecs[i].et, vecs[i].eoff);
      @(negedge clock);
      sb_check($sformatf("vec%0d", i));
    end
    next_cyc();
    instruction = NOP; flag_we = 1'b0; flag_in = 1'b0;
    expect_out(1, 7'd96, 1, 0, 1, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("done3");
    chk("done3.cycle_count", cycle_count, ec(9));
    chk("done3.taken_count", taken_count, ec(3));
    next_cyc();                         // request already low -> IDLE
    program_select = 2'd0;
    expect_out(1, 7'd0, 1, 0, 0, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("idle3");

    // ---------------- asynchronous reset mid-RUN ----------------
    next_cyc(); request = 1'b1; instruction = 9'h1A0;
    @(negedge clock);
    next_cyc();                         // START
    @(negedge clock);
    next_cyc();                         // RUN
    @(negedge clock);
    next_cyc();                         // RUN
    expect_out(0, 7'd0, 0, 1, 0, 1, 1, 5'd0);
    @(negedge clock);
    sb_check("run_before_reset");
    chk("run_before_reset.taken_count", taken_count, ec(1));
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    request = 1'b0;
    #1;
    expect_out(1, 7'd0, 1, 0, 0, 0, 0, 5'd0);
    sb_check("async_reset");
    chk("async_reset.cycle_count", cycle_count, 16'd0);
    chk("async_reset.taken_count", taken_count, 16'd0);
    next_cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_out(1, 7'd0, 1, 0, 0, 0, 0, 5'd0);
      @(negedge clock);
      sb_check($sformatf("post_reset%0d", i));
      next_cyc();
    end

    // ---------------- long JMP loop: saturation ----------------
    request = 1'b1; program_select = 2'd0; instruction = 9'h1A0;
    next_cyc();                         // START
    next_cyc();                         // first RUN cycle
    repeat (PERF ? 70000 : 50) @(posedge clock);
    #1;
    expect_out(0, 7'd0, 0, 1, 0, 1, 1, 5'd0);
    @(negedge clock);
    sb_check("long_loop");
    chk("long_loop.cycle_count", cycle_count, PERF ? 16'hFFFF : 16'd0);
    chk("long_loop.taken_count", taken_count, PERF ? 16'hFFFF : 16'd0);
    next_cyc(); instruction = HALT;
    @(negedge clock);
    next_cyc(); request = 1'b0; instruction = NOP;
    expect_out(1, 7'd0, 1, 0, 1, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("long_done");
    chk("long_done.cycle_count", cycle_count, PERF ? 16'hFFFF : 16'd0);
    chk("long_done.taken_count", taken_count, PERF ? 16'hFFFF : 16'd0);
    next_cyc();
    expect_out(1, 7'd0, 1, 0, 0, 0, 0, 5'd0);
    @(negedge clock);
    sb_check("long_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_branch_control
`default_nettype wire
